// File: rtl/mips_cpu_bus_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store for one Avalon-style bus.
// Holds bus fields stable through stalls, pulses done for one cycle, aborts long stalls.
module mips_cpu_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_address,
  output logic        i_done,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic        grant_d;
  logic        last_d;
  logic [7:0]  wait_cnt;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        pick_d;
  logic        grant_go;
  logic        bypass;
  logic        bus_ok;
  logic        bus_abort;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    state_next = state;
    pick_d     = d_req && (!i_req || !last_d);
    grant_go   = 1'b0;
    bypass     = 1'b0;
    bus_ok     = 1'b0;
    bus_abort  = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant_go   = 1'b1;
          bypass     = pick_d && (d_byteenable == 4'b0000);
          state_next = bypass ? RESP : BUS;
        end
      end
      BUS: begin
        if (!waitrequest) begin
          bus_ok     = 1'b1;
          state_next = RESP;
        end else if (wait_cnt == WAIT_LAST) begin
          bus_abort  = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Bus fields are captured once at grant and only the strobes change afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      grant_d    <= 1'b0;
      last_d     <= 1'b0;
      wait_cnt   <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (grant_go) begin
        grant_d  <= pick_d;
        wait_cnt <= '0;
        if (pick_d) begin
          address    <= d_address;
          writedata  <= d_writedata;
          byteenable <= d_byteenable;
          read       <= !d_write && !bypass;
          write      <= d_write && !bypass;
        end else begin
          address    <= i_address;
          writedata  <= '0;
          byteenable <= 4'hF;
          read       <= 1'b1;
          write      <= 1'b0;
        end
        if (bypass) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
      end
      if (bus_ok) begin
        rdata_q <= read ? readdata : 32'h0;
        err_q   <= 1'b0;
        read    <= 1'b0;
        write   <= 1'b0;
      end else if (bus_abort) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
        read    <= 1'b0;
        write   <= 1'b0;
      end else if (state == BUS) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (state == RESP) last_d <= grant_d;
    end
  end

  assign i_done  = (state == RESP) && !grant_d;
  assign d_done  = (state == RESP) && grant_d;
  assign i_rdata = i_done ? rdata_q : 32'h0;
  assign d_rdata = d_done ? rdata_q : 32'h0;
  assign i_err   = i_done && err_q;
  assign d_err   = d_done && err_q;

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Scoreboard bench for mips_cpu_bus_arbiter: a transaction-level model predicts each
// completion and each bus cycle; a slave process and a done monitor check them.
module tb_mips_cpu_bus_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req = 1'b0;
  logic [31:0] i_address = '0;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_address = '0;
  logic [31:0] d_writedata = '0;
  logic [3:0]  d_byteenable = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;

  mips_cpu_bus_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_address(i_address), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
    int          done_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          stalls;
    logic [31:0] data;
    int          len;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  bit    last_d = 1'b0;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  // Transaction-level prediction: bus length, error and read data follow from the stall count.
  task automatic model_txn(input bit is_d, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input int stalls,
                           input logic [31:0] data, input int g, output int done_cyc);
    exp_t  e;
    plan_t p;
    int    len;
    bit    err;
    e.is_d = is_d;
    if (is_d && be == 4'b0000) begin
      e.rdata = '0;
      e.err = 1'b0;
      e.done_cyc = g;
    end else begin
      err = (stalls >= T);
      len = err ? T : stalls + 1;
      e.err = err;
      e.rdata = err ? 32'h0 : ((is_d && wr) ? 32'h0 : data);
      e.done_cyc = g + len;
      p = '{addr: addr, wr: is_d && wr, wdata: wdata, be: is_d ? be : 4'hF,
            stalls: stalls, data: data, len: len};
      plan_q.push_back(p);
    end
    done_cyc = e.done_cyc;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input bit do_i, input logic [31:0] ia,
                                input bit do_d, input bit dw, input logic [31:0] da,
                                input logic [31:0] dwd, input logic [3:0] dbe,
                                input int st_i, input logic [31:0] dat_i,
                                input int st_d, input logic [31:0] dat_d);
    int  g;
    int  dc;
    int  budget;
    bit  first_d;
    bit  pend_i;
    bit  pend_d;
    bit  seen_i;
    bit  seen_d;
    @(posedge clk);
    #1;
    g = cyc + 1;
    first_d = do_d && (!do_i || !last_d);
    if (do_i && do_d) begin
      if (first_d) begin
        model_txn(1'b1, dw, da, dwd, dbe, st_d, dat_d, g, dc);
        model_txn(1'b0, 1'b0, ia, 32'h0, 4'hF, st_i, dat_i, dc + 2, dc);
        last_d = 1'b0;
      end else begin
        model_txn(1'b0, 1'b0, ia, 32'h0, 4'hF, st_i, dat_i, g, dc);
        model_txn(1'b1, dw, da, dwd, dbe, st_d, dat_d, dc + 2, dc);
        last_d = 1'b1;
      end
    end else if (do_d) begin
      model_txn(1'b1, dw, da, dwd, dbe, st_d, dat_d, g, dc);
      last_d = 1'b1;
    end else if (do_i) begin
      model_txn(1'b0, 1'b0, ia, 32'h0, 4'hF, st_i, dat_i, g, dc);
      last_d = 1'b0;
    end
    i_address = ia;
    d_write = dw;
    d_address = da;
    d_writedata = dwd;
    d_byteenable = dbe;
    i_req = do_i;
    d_req = do_d;
    pend_i = do_i;
    pend_d = do_d;
    budget = 40;
    while ((pend_i || pend_d) && budget > 0) begin
      @(negedge clk);
      seen_i = i_done;
      seen_d = d_done;
      @(posedge clk);
      #1;
      if (seen_i) begin i_req = 1'b0; pend_i = 1'b0; end
      if (seen_d) begin d_req = 1'b0; pend_d = 1'b0; end
      budget--;
    end
    if (pend_i || pend_d) begin
      check_output("round_timeout", 128'({pend_i, pend_d}), 128'(0));
      i_req = 1'b0;
      d_req = 1'b0;
      exp_q.delete();
      plan_q.delete();
      repeat (T + 4) @(posedge clk);
      #1;
    end
  endtask

  // Done monitor: every completion pulse must match the next predicted completion.
  always @(negedge clk) begin
    exp_t e;
    if (i_done || d_done) begin
      check_output("dual_done", 128'(i_done & d_done), 128'(0));
      if (exp_q.size() == 0) begin
        check_output("unexpected_done", 128'({i_done, d_done}), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check_output("done_who", 128'({i_done, d_done}), 128'(e.is_d ? 2'b01 : 2'b10));
        check_output("done_rdata", 128'(e.is_d ? d_rdata : i_rdata), 128'(e.rdata));
        check_output("done_err", 128'(e.is_d ? d_err : i_err), 128'(e.err));
        check_output("done_cycle", 128'(cyc), 128'(e.done_cyc));
      end
    end
  end

  // Slave: plays out the planned stall pattern and checks the bus fields every strobe cycle.
  int    scnt = 0;
  plan_t cur = '{addr: 0, wr: 0, wdata: 0, be: 0, stalls: 0, data: 0, len: 1};
  always @(negedge clk) begin
    if (!reset_n) begin
      scnt = 0;
      waitrequest = 1'b0;
    end else if (read || write) begin
      if (scnt == 0) begin
        if (plan_q.size() == 0) begin
          check_output("unplanned_bus", 128'({read, write}), 128'(0));
          cur = '{addr: 0, wr: 0, wdata: 0, be: 0, stalls: 0, data: 0, len: 1};
        end else begin
          cur = plan_q.pop_front();
        end
      end
      check_output("bus_fields",
                   128'({address, byteenable, write, read, write ? writedata : 32'h0}),
                   128'({cur.addr, cur.be, cur.wr, !cur.wr, cur.wr ? cur.wdata : 32'h0}));
      waitrequest = (scnt < cur.stalls);
      readdata = (waitrequest || cur.wr) ? $urandom : cur.data;
      scnt++;
    end else begin
      if (scnt > 0) check_output("bus_len", 128'(scnt), 128'(cur.len));
      scnt = 0;
      waitrequest = 1'($urandom_range(0, 1));
      readdata = $urandom;
    end
  end

  initial begin
    int          mode;
    logic [3:0]  be;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_state",
                 128'({read, write, address, writedata, byteenable, i_done, d_done, i_err, d_err}),
                 128'(0));
    check_output("reset_rdata", 128'({i_rdata, d_rdata}), 128'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;

    $display("[TB] tie from reset, then tie again");
    apply_stimulus(1, 32'h0040_0000, 1, 0, 32'h1000_0010, 32'h0, 4'hF, 0, 32'h1111_1111, 1, 32'h2222_2222);
    apply_stimulus(1, 32'h0040_0004, 1, 1, 32'h1000_0020, 32'hCAFE_F00D, 4'hF, 2, 32'h3333_3333, 0, 32'h0);

    $display("[TB] single fetch, stalled store, timeout, boundary stall");
    apply_stimulus(1, 32'hBFC0_0000, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h8C22_0004, 0, 32'h0);
    apply_stimulus(0, 32'h0, 1, 1, 32'h0000_1000, 32'h0000_AB00, 4'b0010, 0, 32'h0, 3, 32'h0);
    apply_stimulus(0, 32'h0, 1, 0, 32'h0000_2000, 32'h0, 4'hF, 0, 32'h0, 10, 32'hDEAD_BEEF);
    apply_stimulus(0, 32'h0, 1, 0, 32'h0000_2004, 32'h0, 4'hC, 0, 32'h0, T - 1, 32'h1234_5678);
    apply_stimulus(1, 32'h0040_0008, 0, 0, 32'h0, 32'h0, 4'h0, T, 32'h5555_AAAA, 0, 32'h0);

    $display("[TB] zero-enable bypass");
    apply_stimulus(0, 32'h0, 1, 0, 32'h0000_3000, 32'h0, 4'h0, 0, 32'h0, 0, 32'h9999_9999);
    apply_stimulus(1, 32'h0040_000C, 1, 1, 32'h0000_3004, 32'hFFFF_FFFF, 4'h0, 1, 32'h7777_0000, 0, 32'h0);

    $display("[TB] reset during a stalled bus cycle");
    @(posedge clk);
    #1;
    i_address = 32'h0040_0100;
    i_req = 1'b1;
    plan_q.push_back('{addr: 32'h0040_0100, wr: 0, wdata: 0, be: 4'hF, stalls: 100, data: 0, len: 0});
    @(negedge clk);
    @(negedge clk);
    check_output("pre_reset_read", 128'(read), 128'(1));
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check_output("reset_strobe_drop", 128'({read, write, i_done, d_done}), 128'(0));
    i_req = 1'b0;
    last_d = 1'b0;
    plan_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    apply_stimulus(1, 32'h0040_0200, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'hABCD_0123, 0, 32'h0);
    apply_stimulus(1, 32'h0040_0204, 1, 0, 32'h0000_4000, 32'h0, 4'h3, 0, 32'h0BAD_CAFE, 0, 32'h600D_F00D);

    $display("[TB] randomized rounds");
    for (int r = 0; r < 60; r++) begin
      mode = $urandom_range(1, 3);
      be = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      apply_stimulus(mode[0], $urandom, mode[1], 1'($urandom), $urandom, $urandom, be,
                     $urandom_range(0, T + 1), $urandom, $urandom_range(0, T + 1), $urandom);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    check_output("exp_q_drained", 128'(exp_q.size()), 128'(0));
    check_output("plan_q_drained", 128'(plan_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
